mem_master: RTL and testbench

- Initiator-side sequencer for the single-port word memory: combinational read, synchronous write, one address bus.
- Accepts single or burst read/write requests from the CPU core over ready/valid handshakes.
- Drives registered mem_addr, mem_we and mem_data toward the memory and returns read words with backpressure.
- Sits between the CPU datapath and the memory instance; it is the only driver of the memory port.

---
 rtl/mem_master_pkg.sv | 16 +
 rtl/mem_master.sv | 132 +++++++++++++
 tb/tb_mem_master.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_master_pkg.sv
// rtl/mem_master_pkg.sv - shared state encoding and default widths for mem_master
package mem_master_pkg;

    localparam int DEF_ADDR_WIDTH = 6;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_LEN_WIDTH  = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_SETUP  = 3'd1,
        RD_HOLD   = 3'd2,
        WR_WAIT   = 3'd3,
        WR_COMMIT = 3'd4
    } state_t;

endpackage

// File: rtl/mem_master.sv
// rtl/mem_master.sv - burst read/write sequencer driving a single-port word memory
module mem_master
    import mem_master_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]  req_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mem_out
);

    state_t               state;
    state_t               next_state;
    logic [LEN_WIDTH-1:0] cnt;

    // Handshake and status outputs decode straight from the state so they
    // change on the same edge as the state itself.
    assign req_ready = (state == IDLE);
    assign wr_ready  = (state == WR_WAIT);
    assign busy      = (state != IDLE);

    // State register; reset aborts any burst in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state selection.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    next_state = req_we ? WR_WAIT : RD_SETUP;
                end
            end
            RD_SETUP: begin
                next_state = RD_HOLD;
            end
            RD_HOLD: begin
                if (rd_ready) begin
                    next_state = (cnt == '0) ? IDLE : RD_SETUP;
                end
            end
            WR_WAIT: begin
                if (wr_valid) begin
                    next_state = WR_COMMIT;
                end
            end
            WR_COMMIT: begin
                next_state = (cnt == '0) ? IDLE : WR_WAIT;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath registers: address/count, memory-side write strobe and the
    // read word held for the consumer. mem_we clears asynchronously so a
    // reset inside WR_COMMIT never lets the pending write reach the memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            mem_addr <= '0;
            mem_we   <= 1'b0;
            mem_data <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        mem_addr <= req_addr;
                        cnt      <= req_len;
                    end
                end
                RD_SETUP: begin
                    rd_data  <= mem_out;
                    rd_valid <= 1'b1;
                end
                RD_HOLD: begin
                    if (rd_ready) begin
                        rd_valid <= 1'b0;
                        if (cnt != '0) begin
                            cnt      <= cnt - LEN_WIDTH'(1);
                            mem_addr <= mem_addr + ADDR_WIDTH'(1);
                        end
                    end
                end
                WR_WAIT: begin
                    if (wr_valid) begin
                        mem_data <= wr_data;
                        mem_we   <= 1'b1;
                    end
                end
                WR_COMMIT: begin
                    mem_we <= 1'b0;
                    if (cnt != '0) begin
                        cnt      <= cnt - LEN_WIDTH'(1);
                        mem_addr <= mem_addr + ADDR_WIDTH'(1);
                    end
                end
                default: begin
                    mem_we   <= 1'b0;
                    rd_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_master.sv
// tb/tb_mem_master.sv - self-checking bench for mem_master against a shadow memory model
module tb_mem_master;

    localparam int AW = 6;
    localparam int DW = 16;
    localparam int LW = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [LW-1:0] req_len = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] wr_data = '0;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_data;
    logic [DW-1:0] mem_out;

    int n_checks = 0;
    int n_fail   = 0;

    // target memory: combinational read, synchronous write
    logic [DW-1:0] mem [DEPTH];
    // reference model: what each address must contain after the bursts issued
    logic [DW-1:0] shadow [DEPTH];

    assign mem_out = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_data;
    end

    always #5 clk = ~clk;

    mem_master dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_data  (mem_data),
        .mem_out   (mem_out)
    );

    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        logic [DW-1:0] seed;
        logic [DW-1:0] step;
        int            stall;
        int            bp;
        logic [DW-1:0] exp_first;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Write burst starting at a negedge; word i = seed + step*i.
    task automatic write_burst(input logic [AW-1:0] a, input logic [LW-1:0] l,
                               input logic [DW-1:0] seed, input logic [DW-1:0] step,
                               input int stall);
        logic [DW-1:0] d;
        logic [AW-1:0] ea;
        int            stall_at;
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_len = l;
        chk("wr_req_ready", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        ea = a;
        stall_at = (l == 0) ? 0 : 1;
        for (int i = 0; i <= int'(l); i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < stall; s++) begin
                    chk("stall_wr_ready", wr_ready, 1);
                    chk("stall_mem_we", mem_we, 0);
                    chk("stall_mem_addr", mem_addr, ea);
                    @(negedge clk);
                end
            end
            d = seed + step * DW'(i);
            wr_valid = 1'b1; wr_data = d;
            chk("wr_ready", wr_ready, 1);
            @(negedge clk);
            wr_valid = 1'b0; wr_data = ~d;
            chk("commit_mem_we", mem_we, 1);
            chk("commit_mem_addr", mem_addr, ea);
            chk("commit_mem_data", mem_data, d);
            chk("commit_wr_ready", wr_ready, 0);
            shadow[ea] = d;
            @(negedge clk);
            chk("post_commit_mem_we", mem_we, 0);
            ea = ea + AW'(1);
        end
        chk("wr_end_busy", busy, 0);
        chk("wr_end_req_ready", req_ready, 1);
    endtask

    // Read burst starting at a negedge; bp cycles of backpressure on word 0.
    // With intrude set, a competing request is held up for the whole burst.
    task automatic read_burst(input logic [AW-1:0] a, input logic [LW-1:0] l,
                              input int bp, input bit intrude, input logic [AW-1:0] ia,
                              output logic [DW-1:0] first);
        logic [AW-1:0] ea;
        first = '0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_len = l;
        chk("rd_req_ready", req_ready, 1);
        @(negedge clk);
        if (intrude) begin
            req_valid = 1'b1; req_addr = ia; req_we = 1'b0; req_len = '0;
        end else begin
            req_valid = 1'b0;
        end
        ea = a;
        for (int i = 0; i <= int'(l); i++) begin
            chk("setup_rd_valid", rd_valid, 0);
            chk("setup_mem_addr", mem_addr, ea);
            chk("setup_mem_we", mem_we, 0);
            if (intrude) chk("busy_req_ready", req_ready, 0);
            @(negedge clk);
            chk("hold_rd_valid", rd_valid, 1);
            chk("hold_rd_data", rd_data, shadow[ea]);
            if (i == 0) first = rd_data;
            if (i == 0) begin
                for (int s = 0; s < bp; s++) begin
                    @(negedge clk);
                    chk("bp_rd_valid", rd_valid, 1);
                    chk("bp_rd_data", rd_data, shadow[ea]);
                    chk("bp_mem_addr", mem_addr, ea);
                    chk("bp_busy", busy, 1);
                end
            end
            rd_ready = 1'b1;
            @(negedge clk);
            rd_ready = 1'b0;
            ea = ea + AW'(1);
        end
        chk("rd_end_busy", busy, 0);
        chk("rd_end_rd_valid", rd_valid, 0);
    endtask

    vec_t          vecs [6];
    logic [DW-1:0] first;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]    = DW'(i * 3 + 7);
            shadow[i] = DW'(i * 3 + 7);
        end

        vecs[0] = '{1'b1, 6'd5,  4'd0, 16'hBEEF, 16'h0000, 0, 0, 16'h0000};
        vecs[1] = '{1'b0, 6'd5,  4'd0, 16'h0000, 16'h0000, 0, 0, 16'hBEEF};
        vecs[2] = '{1'b1, 6'd62, 4'd3, 16'h0011, 16'h0011, 0, 0, 16'h0000};
        vecs[3] = '{1'b0, 6'd62, 4'd3, 16'h0000, 16'h0000, 0, 0, 16'h0011};
        vecs[4] = '{1'b1, 6'd10, 4'd2, 16'hA000, 16'h0101, 4, 0, 16'h0000};
        vecs[5] = '{1'b0, 6'd0,  4'd1, 16'h0000, 16'h0000, 0, 5, 16'h0033};

        // reset values
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_data", mem_data, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_wr_ready", wr_ready, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // directed table
        for (int v = 0; v < 6; v++) begin
            if (vecs[v].we) begin
                write_burst(vecs[v].addr, vecs[v].len, vecs[v].seed, vecs[v].step, vecs[v].stall);
            end else begin
                read_burst(vecs[v].addr, vecs[v].len, vecs[v].bp, 1'b0, '0, first);
                chk("table_first_word", first, vecs[v].exp_first);
            end
        end

        // request while busy: held competing request waits for IDLE
        read_burst(6'd62, 4'd1, 2, 1'b1, 6'd5, first);
        chk("intrude_first", first, 16'h0011);
        chk("intrude_idle_ready", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("intrude_accept_addr", mem_addr, 5);
        chk("intrude_accept_busy", busy, 1);
        @(negedge clk);
        chk("intrude_rd_valid", rd_valid, 1);
        chk("intrude_rd_data", rd_data, 16'hBEEF);
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        chk("intrude_done_busy", busy, 0);

        // randomized bursts against the shadow model
        for (int r = 0; r < 30; r++) begin
            if ($urandom_range(0, 1) == 1) begin
                write_burst(AW'($urandom_range(0, DEPTH - 1)), LW'($urandom_range(0, 15)),
                            DW'($urandom), DW'($urandom), $urandom_range(0, 3));
            end else begin
                read_burst(AW'($urandom_range(0, DEPTH - 1)), LW'($urandom_range(0, 15)),
                           $urandom_range(0, 3), 1'b0, '0, first);
            end
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        // full sweep of memory contents
        for (int k = 0; k < 4; k++) begin
            read_burst(AW'(k * 16), 4'd15, 0, 1'b0, '0, first);
        end

        // reset during WR_COMMIT: pending write must not land
        req_valid = 1'b1; req_we = 1'b1; req_addr = 6'd20; req_len = 4'd3;
        @(negedge clk);
        req_valid = 1'b0;
        wr_valid = 1'b1; wr_data = ~shadow[20];
        @(negedge clk);
        wr_valid = 1'b0;
        chk("pre_rst_mem_we", mem_we, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_mem_we", mem_we, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_rd_valid", rd_valid, 0);
        chk("midrst_req_ready", req_ready, 1);
        chk("midrst_wr_ready", wr_ready, 0);
        @(negedge clk);
        chk("midrst_no_write", mem[20], shadow[20]);
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_mem_addr", mem_addr, 0);
        chk("postrst_busy", busy, 0);
        chk("postrst_rd_valid", rd_valid, 0);

        // still functional after reset
        read_burst(6'd20, 4'd0, 1, 1'b0, '0, first);
        chk("postrst_read", first, shadow[20]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
